// File: rtl/ula_muldiv.sv
// RV32M multiply/divide unit: multiplier with a MUL_STAGES-deep product pipeline
// and a restoring divider (one quotient bit per cycle), behind a four-state FSM.
module ula_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FIN} state_t;

    state_t            state_reg, state_next;
    logic              accept;
    logic [2:0]        f3_reg;
    logic [XLEN-1:0]   a_reg, b_reg;
    logic [2:0]        mul_cnt_reg;
    logic [CNT_W-1:0]  div_cnt_reg;
    logic [XLEN-1:0]   quo_reg, rem_reg, dvsr_reg;
    logic              neg_q_reg, neg_r_reg, div_special_reg;
    logic [XLEN-1:0]   result_reg;

    // Operand conditioning for the divider, evaluated on the raw request.
    logic              signed_div, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_val;

    assign signed_div  = ~funct3[0];
    assign a_neg       = signed_div & op_a[XLEN-1];
    assign b_neg       = signed_div & op_b[XLEN-1];
    assign a_mag       = a_neg ? -op_a : op_a;
    assign b_mag       = b_neg ? -op_b : op_b;
    assign div_zero    = (op_b == '0);
    assign div_ovf     = signed_div && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign special_val = funct3[1] ? (div_zero ? op_a : '0)
                                   : (div_zero ? '1   : op_a);

    // Multiplier: sign-extend per op so one 2*XLEN product covers all four variants.
    logic              a_signed, b_signed;
    logic [2*XLEN-1:0] a_ext, b_ext, product_comb, mul_final;
    logic [XLEN-1:0]   mul_sel;

    assign a_signed     = (f3_reg[1:0] == 2'b01) || (f3_reg[1:0] == 2'b10);
    assign b_signed     = (f3_reg[1:0] == 2'b01);
    assign a_ext        = {{XLEN{a_signed & a_reg[XLEN-1]}}, a_reg};
    assign b_ext        = {{XLEN{b_signed & b_reg[XLEN-1]}}, b_reg};
    assign product_comb = a_ext * b_ext;
    assign mul_sel      = (f3_reg[1:0] == 2'b00) ? mul_final[XLEN-1:0]
                                                 : mul_final[2*XLEN-1:XLEN];

    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign mul_final = product_comb;
        end else begin : g_mul_pipe
            logic [2*XLEN-1:0] pipe_reg [MUL_STAGES-1];
            for (genvar gi = 0; gi < MUL_STAGES - 1; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) begin
                        if (rst) pipe_reg[gi] <= '0;
                        else     pipe_reg[gi] <= product_comb;
                    end
                end else begin : g_next
                    always_ff @(posedge clk) begin
                        if (rst) pipe_reg[gi] <= '0;
                        else     pipe_reg[gi] <= pipe_reg[gi-1];
                    end
                end
            end
            assign mul_final = pipe_reg[MUL_STAGES-2];
        end
    endgenerate

    // Restoring divider step: shift the dividend MSB into the partial remainder.
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff, div_final;
    logic            rem_ge;

    assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
    assign rem_ge    = rem_shift >= {1'b0, dvsr_reg};
    assign rem_diff  = rem_shift[XLEN-1:0] - dvsr_reg;
    assign div_final = div_special_reg ? quo_reg
                     : f3_reg[1]       ? (neg_r_reg ? -rem_reg : rem_reg)
                                       : (neg_q_reg ? -quo_reg : quo_reg);

    logic mul_last, div_last, load_result;

    assign mul_last    = (state_reg == MUL_RUN) && (mul_cnt_reg == 3'(MUL_STAGES - 1));
    assign div_last    = (state_reg == DIV_RUN) &&
                         (div_special_reg || (div_cnt_reg == CNT_W'(XLEN)));
    assign load_result = !flush && (mul_last || div_last);

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        unique case (state_reg)
            IDLE, FIN: begin
                if (start && !flush) begin
                    accept     = 1'b1;
                    state_next = funct3[2] ? DIV_RUN : MUL_RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            MUL_RUN: begin
                if (flush)         state_next = IDLE;
                else if (mul_last) state_next = FIN;
            end
            DIV_RUN: begin
                if (flush)         state_next = IDLE;
                else if (div_last) state_next = FIN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            f3_reg          <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            mul_cnt_reg     <= '0;
            div_cnt_reg     <= '0;
            quo_reg         <= '0;
            rem_reg         <= '0;
            dvsr_reg        <= '0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            div_special_reg <= 1'b0;
            result_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                f3_reg          <= funct3;
                a_reg           <= op_a;
                b_reg           <= op_b;
                mul_cnt_reg     <= '0;
                div_cnt_reg     <= '0;
                quo_reg         <= (div_zero || div_ovf) ? special_val : a_mag;
                rem_reg         <= '0;
                dvsr_reg        <= b_mag;
                neg_q_reg       <= a_neg ^ b_neg;
                neg_r_reg       <= a_neg;
                div_special_reg <= div_zero || div_ovf;
            end else if (state_reg == MUL_RUN) begin
                mul_cnt_reg <= mul_cnt_reg + 3'd1;
            end else if (state_reg == DIV_RUN && !div_last) begin
                div_cnt_reg <= div_cnt_reg + CNT_W'(1);
                quo_reg     <= {quo_reg[XLEN-2:0], rem_ge};
                rem_reg     <= rem_ge ? rem_diff : rem_shift[XLEN-1:0];
            end
            if (load_result)
                result_reg <= f3_reg[2] ? div_final : mul_sel;
        end
    end

    assign busy   = (state_reg == MUL_RUN) || (state_reg == DIV_RUN);
    assign done   = (state_reg == FIN);
    assign result = result_reg;

endmodule

// File: tb/tb_ula_muldiv.sv
// Bench for ula_muldiv: two instances (32-bit/2-stage and 16-bit/4-stage), directed
// vectors, flush/reset sequences and random ops against an arithmetic reference model.
module tb_ula_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [2];
    logic [2:0]  f3_s    [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic        flush_s [2];
    logic        busy_o  [2];
    logic        done_o  [2];
    logic [31:0] res32;
    logic [15:0] res16;

    int          tests  = 0;
    int          fails  = 0;
    logic [31:0] last_res [2];

    localparam int XL [2] = '{32, 16};
    localparam int MS [2] = '{2, 4};

    always #5 clk = ~clk;

    ula_muldiv #(.XLEN(32), .MUL_STAGES(2)) dut32 (
        .clk(clk), .rst(rst), .start(start_s[0]), .funct3(f3_s[0]),
        .op_a(a_s[0]), .op_b(b_s[0]), .flush(flush_s[0]),
        .busy(busy_o[0]), .done(done_o[0]), .result(res32)
    );

    ula_muldiv #(.XLEN(16), .MUL_STAGES(4)) dut16 (
        .clk(clk), .rst(rst), .start(start_s[1]), .funct3(f3_s[1]),
        .op_a(a_s[1][15:0]), .op_b(b_s[1][15:0]), .flush(flush_s[1]),
        .busy(busy_o[1]), .done(done_o[1]), .result(res16)
    );

    typedef struct {
        int          inst;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [31:0] res_of(input int inst);
        return (inst == 1) ? {16'h0, res16} : res32;
    endfunction

    function automatic logic [31:0] mask_of(input int xl);
        return (xl == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // Reference model: plain wide signed arithmetic on the architectural rules.
    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input int xl);
        logic signed [127:0] ua, ub, sa, sb, p, minv;
        logic [31:0] m, a, b, r;
        m  = mask_of(xl);
        a  = a_in & m;
        b  = b_in & m;
        ua = 128'(a);
        ub = 128'(b);
        sa = a[xl-1] ? ua - (128'sd1 <<< xl) : ua;
        sb = b[xl-1] ? ub - (128'sd1 <<< xl) : ub;
        minv = -(128'sd1 <<< (xl - 1));
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = (sa * sb) >>> xl; r = p[31:0]; end
            3'd2: begin p = (sa * ub) >>> xl; r = p[31:0]; end
            3'd3: begin p = (ua * ub) >>> xl; r = p[31:0]; end
            3'd4: begin
                if (b == 0) r = m;
                else if (sa == minv && sb == -128'sd1) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = m;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (sa == minv && sb == -128'sd1) r = 0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r & m;
    endfunction

    function automatic int lat_model(input int inst, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
        int xl;
        logic [31:0] m, minv;
        xl   = XL[inst];
        m    = mask_of(xl);
        minv = 32'h1 << (xl - 1);
        if (!f3[2]) return MS[inst];
        if ((b & m) == 0) return 1;
        if (!f3[0] && (a & m) == minv && (b & m) == m) return 1;
        return xl + 1;
    endfunction

    function automatic logic [31:0] pick_operand(input int xl);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h1 << (xl - 1);
            3:       v = 32'($urandom_range(1, 9));
            default: v = $urandom;
        endcase
        return v & mask_of(xl);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request: accept, then track latency, busy and (optionally) ignored mid-op starts.
    task automatic do_op(input int inst, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int exp_l,
                         input bit pulse, input string name);
        int lat;
        bit seen;
        bit busy_ok;
        lat = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_s[inst] = 1'b1;
        f3_s[inst] = f3;
        a_s[inst] = a;
        b_s[inst] = b;
        @(posedge clk);
        while (!seen && lat <= 200) begin
            @(negedge clk);
            start_s[inst] = 1'b0;
            a_s[inst] = $urandom & mask_of(XL[inst]);
            b_s[inst] = $urandom & mask_of(XL[inst]);
            f3_s[inst] = 3'($urandom_range(0, 7));
            if (done_o[inst]) begin
                seen = 1'b1;
            end else begin
                if (!busy_o[inst]) busy_ok = 1'b0;
                lat++;
                if (pulse && (lat % 3 == 1)) start_s[inst] = 1'b1;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'(1));
        check({name, "_latency"}, 64'(lat), 64'(exp_l));
        check({name, "_result"}, 64'(res_of(inst)), 64'(exp_r));
        check({name, "_busy_run"}, 64'(busy_ok), 64'(1));
        $display("[TB] %s inst%0d f3=%0d a=%h b=%h result=%h exp=%h lat=%0d exp_lat=%0d",
                 name, inst, f3, a, b, res_of(inst), exp_r, lat, exp_l);
        @(negedge clk);
        check({name, "_after_idle"}, {62'h0, busy_o[inst], done_o[inst]}, 64'h0);
        last_res[inst] = exp_r;
    endtask

    task automatic flush_seq(input int inst);
        bit done_seen;
        logic [31:0] m;
        done_seen = 1'b0;
        m = mask_of(XL[inst]);
        @(negedge clk);
        start_s[inst] = 1'b1;
        f3_s[inst] = 3'b100;
        a_s[inst] = 32'hFFFF_FFEC & m;
        b_s[inst] = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_s[inst] = 1'b0;
        repeat (9) @(negedge clk);
        flush_s[inst] = 1'b1;
        @(negedge clk);
        flush_s[inst] = 1'b0;
        check($sformatf("flush%0d_state", inst), {62'h0, busy_o[inst], done_o[inst]}, 64'h0);
        check($sformatf("flush%0d_result_held", inst), 64'(res_of(inst)), 64'(last_res[inst]));
        $display("[TB] flush inst%0d busy=%0d done=%0d result=%h", inst, busy_o[inst],
                 done_o[inst], res_of(inst));
        repeat (40) begin
            @(negedge clk);
            if (done_o[inst]) done_seen = 1'b1;
        end
        check($sformatf("flush%0d_no_done", inst), 64'(done_seen), 64'h0);
        do_op(inst, 3'b000, 32'd3, 32'd4, 32'd12, MS[inst], 1'b0, "flush_mul");
        // Flush and start together: the request must be dropped.
        @(negedge clk);
        start_s[inst] = 1'b1;
        flush_s[inst] = 1'b1;
        f3_s[inst] = 3'b000;
        @(negedge clk);
        start_s[inst] = 1'b0;
        flush_s[inst] = 1'b0;
        check($sformatf("flush%0d_prio_busy", inst), 64'(busy_o[inst]), 64'h0);
        $display("[TB] flush+start inst%0d busy=%0d", inst, busy_o[inst]);
    endtask

    task automatic reset_seq(input int inst);
        logic [31:0] m;
        m = mask_of(XL[inst]);
        @(negedge clk);
        start_s[inst] = 1'b1;
        f3_s[inst] = 3'b100;
        a_s[inst] = 32'hFFFF_FFEC & m;
        b_s[inst] = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_s[inst] = 1'b0;
        repeat (4) @(negedge clk);
        check($sformatf("rst%0d_busy_before", inst), 64'(busy_o[inst]), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("rst%0d_state", inst), {62'h0, busy_o[inst], done_o[inst]}, 64'h0);
        check($sformatf("rst%0d_result", inst), 64'(res_of(inst)), 64'h0);
        $display("[TB] reset inst%0d busy=%0d done=%0d result=%h", inst, busy_o[inst],
                 done_o[inst], res_of(inst));
        last_res[0] = 32'h0;
        last_res[1] = 32'h0;
        do_op(inst, 3'b000, 32'd7, 32'hFFFF_FFFD & m, model(3'b000, 32'd7, 32'hFFFF_FFFD, XL[inst]),
              MS[inst], 1'b0, "rst_first_op");
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            f3_s[i] = 3'b000;
            a_s[i] = 32'h0;
            b_s[i] = 32'h0;
            flush_s[i] = 1'b0;
            last_res[i] = 32'h0;
        end

        vecs.push_back('{0, 3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2});
        vecs.push_back('{0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
        vecs.push_back('{0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2});
        vecs.push_back('{0, 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 2});
        vecs.push_back('{0, 3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33});
        vecs.push_back('{0, 3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33});
        vecs.push_back('{0, 3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{0, 3'd7, 32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back('{0, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back('{1, 3'd0, 32'd7,         32'h0000_FFFD, 32'h0000_FFEB, 4});
        vecs.push_back('{1, 3'd3, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 4});
        vecs.push_back('{1, 3'd1, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 4});
        vecs.push_back('{1, 3'd4, 32'h0000_FFEC, 32'd3,         32'h0000_FFFA, 17});
        vecs.push_back('{1, 3'd6, 32'h0000_FFEC, 32'd3,         32'h0000_FFFE, 17});
        vecs.push_back('{1, 3'd5, 32'd5,         32'd0,         32'h0000_FFFF, 1});
        vecs.push_back('{1, 3'd7, 32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{1, 3'd4, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_8000, 1});
        vecs.push_back('{1, 3'd6, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_0000, 1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d_busy_done", i), {62'h0, busy_o[i], done_o[i]}, 64'h0);
            check($sformatf("reset%0d_result", i), 64'(res_of(i)), 64'h0);
        end

        foreach (vecs[k])
            do_op(vecs[k].inst, vecs[k].f3, vecs[k].a, vecs[k].b, vecs[k].res, vecs[k].lat,
                  1'b1, $sformatf("vec%0d", k));

        for (int i = 0; i < 2; i++) begin
            flush_seq(i);
            reset_seq(i);
        end

        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 40; n++) begin
                logic [2:0]  f3;
                logic [31:0] a, b;
                f3 = 3'($urandom_range(0, 7));
                a  = pick_operand(XL[i]);
                b  = pick_operand(XL[i]);
                do_op(i, f3, a, b, model(f3, a, b, XL[i]), lat_model(i, f3, a, b),
                      1'($urandom_range(0, 1)), $sformatf("rand%0d_%0d", i, n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
